// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine
//   Decodes the draw-sprite command (opcode 0x12) from the command decoder's
//   opcode/operand stream and expands its packed 1/2/4/8 bpp pixel data into
//   one frame-buffer write per visible pixel, with palette offset and clipping.
//
// Ports
//   clock_in, reset_in       single clock, synchronous active-high reset
//   op_code_in/_valid_in     command opcode, valid held for the whole command
//   operand_in/_valid_in     operand byte; valid is a level held >= 2 cycles
//   operand_count_in         1-based index of the operand currently presented
//   pixel_addr_out           (y+row)*DISPLAY_WIDTH + (x+col)
//   pixel_color_out          palette index written to the buffer
//   pixel_valid_out          write request, held until pixel_ready_in
//   pixel_ready_in           buffer accepts when valid && ready
//   busy_out                 engine is not idle
//   overflow_out             sticky: a data byte was dropped
//   error_out                sticky: a width==0 command was received
module sprite_draw_engine #(
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 400,
    parameter int COLOR_BITS     = 4,
    parameter int ADDR_BITS      = 18
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [7:0]            op_code_in,
    input  logic                  op_code_valid_in,
    input  logic [7:0]            operand_in,
    input  logic                  operand_valid_in,
    input  logic [31:0]           operand_count_in,
    output logic [ADDR_BITS-1:0]  pixel_addr_out,
    output logic [COLOR_BITS-1:0] pixel_color_out,
    output logic                  pixel_valid_out,
    input  logic                  pixel_ready_in,
    output logic                  busy_out,
    output logic                  overflow_out,
    output logic                  error_out
);

    localparam logic [7:0] OP_DRAW_SPRITE = 8'h12;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        STREAM,
        IGNORE
    } state_t;

    state_t state, state_next;

    // Slot width implied by the sprite's colour count.
    function automatic logic [3:0] bpp_from_colours(input logic [7:0] colours);
        logic [3:0] bpp;
        if (colours == 8'd0)       bpp = 4'd8;
        else if (colours <= 8'd2)  bpp = 4'd1;
        else if (colours <= 8'd4)  bpp = 4'd2;
        else if (colours <= 8'd16) bpp = 4'd4;
        else                       bpp = 4'd8;
        return bpp;
    endfunction

    // Saturate the used field width to what the buffer can store.
    function automatic logic [3:0] clamp_bpp(input logic [3:0] bpp);
        logic [3:0] r;
        r = bpp;
        if (32'(bpp) > COLOR_BITS) r = 4'(COLOR_BITS);
        return r;
    endfunction

    function automatic logic [3:0] fields_per_byte(input logic [3:0] bpp);
        logic [3:0] n;
        case (bpp)
            4'd1:    n = 4'd8;
            4'd2:    n = 4'd4;
            4'd4:    n = 4'd2;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

    // ---- Stage p0: register operand/opcode inputs for edge detection ----
    logic        op_vld_p0;
    logic        opd_vld_p0;
    logic        opd_vld_p1;
    logic [7:0]  opd_p0;
    logic [31:0] opd_cnt_p0;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            op_vld_p0  <= 1'b0;
            opd_vld_p0 <= 1'b0;
            opd_vld_p1 <= 1'b0;
        end else begin
            op_vld_p0  <= op_code_valid_in;
            opd_vld_p0 <= operand_valid_in;
            opd_vld_p1 <= opd_vld_p0;
        end
        opd_p0     <= operand_in;
        opd_cnt_p0 <= operand_count_in;
    end

    // One operand per rising edge of the registered valid level.
    logic accept;
    logic cmd_start;
    logic hdr_done;
    logic data_in;

    assign accept    = opd_vld_p0 && !opd_vld_p1;
    assign cmd_start = op_code_valid_in && !op_vld_p0 && (op_code_in == OP_DRAW_SPRITE);
    assign hdr_done  = (state == HEADER) && op_code_valid_in && accept && (opd_cnt_p0 == 32'd8);
    assign data_in   = (state == STREAM) && op_code_valid_in && accept && (opd_cnt_p0 >= 32'd9);

    // ---- Stage p1: header registers, unpack/hold buffers, pixel position ----
    logic [15:0] x_r, y_r, w_r;
    logic [7:0]  pal_off_r;
    logic [3:0]  sbpp_r;
    logic [3:0]  cbpp_r;

    logic        unpack_full, hold_full;
    logic [7:0]  unpack_byte, hold_byte;
    logic [3:0]  fields_left;
    logic [15:0] col, row;

    logic [16:0]          sum_x, sum_y;
    logic                 clipped;
    logic [7:0]           slot;
    logic [7:0]           field;
    logic [COLOR_BITS-1:0] pix_color;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic                 out_free;
    logic                 advance;
    logic                 unpack_frees;
    logic                 pending;

    // Sums are 17 bits so an off-screen x or y never wraps back on screen.
    assign sum_x   = {1'b0, x_r} + {1'b0, col};
    assign sum_y   = {1'b0, y_r} + {1'b0, row};
    assign clipped = (sum_x >= 17'(DISPLAY_WIDTH)) || (sum_y >= 17'(DISPLAY_HEIGHT));

    // Current slot sits in the top sbpp bits; only its low cbpp bits are used
    // when the colour count exceeds what COLOR_BITS can hold.
    assign slot      = unpack_byte >> (4'd8 - sbpp_r);
    assign field     = slot & (8'hFF >> (4'd8 - cbpp_r));
    assign pix_color = COLOR_BITS'(pal_off_r) + COLOR_BITS'(field);
    assign pix_addr  = ADDR_BITS'(32'(sum_y) * 32'(DISPLAY_WIDTH) + 32'(sum_x));

    assign out_free     = !pixel_valid_out || pixel_ready_in;
    assign advance      = (state == STREAM) && unpack_full && out_free;
    assign unpack_frees = advance && (fields_left == 4'd1);
    assign pending      = unpack_full || hold_full || pixel_valid_out;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_start) state_next = HEADER;
            end
            HEADER: begin
                if (!op_code_valid_in)  state_next = IDLE;
                else if (hdr_done)      state_next = (w_r == 16'd0) ? IGNORE : STREAM;
            end
            STREAM: begin
                if (!op_code_valid_in && !pending) state_next = IDLE;
            end
            IGNORE: begin
                if (!op_code_valid_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_out = (state != IDLE);

    always_ff @(posedge clock_in) begin
        // Header capture, MSB first for the 16-bit fields.
        if ((state == HEADER) && op_code_valid_in && accept) begin
            case (opd_cnt_p0)
                32'd1: x_r[15:8] <= opd_p0;
                32'd2: x_r[7:0]  <= opd_p0;
                32'd3: y_r[15:8] <= opd_p0;
                32'd4: y_r[7:0]  <= opd_p0;
                32'd5: w_r[15:8] <= opd_p0;
                32'd6: w_r[7:0]  <= opd_p0;
                32'd7: begin
                    sbpp_r <= bpp_from_colours(opd_p0);
                    cbpp_r <= clamp_bpp(bpp_from_colours(opd_p0));
                end
                32'd8: pal_off_r <= opd_p0;
                default: ;
            endcase
        end

        if (reset_in) begin
            pixel_valid_out <= 1'b0;
            pixel_addr_out  <= '0;
            pixel_color_out <= '0;
            unpack_full     <= 1'b0;
            hold_full       <= 1'b0;
            col             <= '0;
            row             <= '0;
            overflow_out    <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            if (hdr_done && (w_r == 16'd0)) error_out <= 1'b1;

            if (state == IDLE) begin
                unpack_full <= 1'b0;
                hold_full   <= 1'b0;
                col         <= '0;
                row         <= '0;
            end

            // ---- Stage p2: output register, one field per free slot ----
            if (advance) begin
                // A clipped pixel still uses this cycle, with valid low.
                pixel_valid_out <= !clipped;
                if (!clipped) begin
                    pixel_addr_out  <= pix_addr;
                    pixel_color_out <= pix_color;
                end
                if (col == w_r - 16'd1) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
                unpack_byte <= unpack_byte << sbpp_r;
                fields_left <= fields_left - 4'd1;
            end else if (pixel_ready_in) begin
                pixel_valid_out <= 1'b0;
            end

            // Buffer refill; hold is only ever full while unpack is full.
            if (data_in) begin
                if (!unpack_full || (unpack_frees && !hold_full)) begin
                    unpack_byte <= opd_p0;
                    fields_left <= fields_per_byte(sbpp_r);
                    unpack_full <= 1'b1;
                end else if (unpack_frees) begin
                    unpack_byte <= hold_byte;
                    fields_left <= fields_per_byte(sbpp_r);
                    hold_byte   <= opd_p0;
                end else if (!hold_full) begin
                    hold_byte <= opd_p0;
                    hold_full <= 1'b1;
                end else begin
                    overflow_out <= 1'b1;
                end
            end else if (unpack_frees) begin
                if (hold_full) begin
                    unpack_byte <= hold_byte;
                    fields_left <= fields_per_byte(sbpp_r);
                    hold_full   <= 1'b0;
                end else begin
                    unpack_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
module tb_sprite_draw_engine;

    localparam int DW = 640;
    localparam int DH = 400;
    localparam int CB = 4;
    localparam int AB = 18;

    logic          clk = 1'b0;
    logic          reset_in;
    logic [7:0]    op_code_in;
    logic          op_code_valid_in;
    logic [7:0]    operand_in;
    logic          operand_valid_in;
    logic [31:0]   operand_count_in;
    logic [AB-1:0] pixel_addr_out;
    logic [CB-1:0] pixel_color_out;
    logic          pixel_valid_out;
    logic          pixel_ready_in;
    logic          busy_out;
    logic          overflow_out;
    logic          error_out;

    always #5 clk = ~clk;

    sprite_draw_engine #(
        .DISPLAY_WIDTH (DW),
        .DISPLAY_HEIGHT(DH),
        .COLOR_BITS    (CB),
        .ADDR_BITS     (AB)
    ) dut (
        .clock_in        (clk),
        .reset_in        (reset_in),
        .op_code_in      (op_code_in),
        .op_code_valid_in(op_code_valid_in),
        .operand_in      (operand_in),
        .operand_valid_in(operand_valid_in),
        .operand_count_in(operand_count_in),
        .pixel_addr_out  (pixel_addr_out),
        .pixel_color_out (pixel_color_out),
        .pixel_valid_out (pixel_valid_out),
        .pixel_ready_in  (pixel_ready_in),
        .busy_out        (busy_out),
        .overflow_out    (overflow_out),
        .error_out       (error_out)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard state
    logic [31:0] got_addr[$];
    logic [31:0] got_col[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_col[$];
    logic [7:0]  data_q[$];
    int          cum[$];

    int wr_total        = 0;
    int stall_cycles    = 0;
    int first_valid_cyc = -1;
    int last_t0         = 0;

    // Ready control
    bit ready_random    = 0;
    bit ready_force_low = 0;
    int stall_at        = -1;

    initial begin
        int stall_cnt;
        stall_cnt = 0;
        pixel_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                pixel_ready_in = 1'b0;
                stall_cnt--;
            end else if (stall_at >= 0 && wr_total == stall_at) begin
                pixel_ready_in = 1'b0;
                stall_cnt = 4;
                stall_at = -1;
            end else if (ready_force_low) begin
                pixel_ready_in = 1'b0;
            end else if (ready_random) begin
                pixel_ready_in = ($urandom_range(0, 3) != 0);
            end else begin
                pixel_ready_in = 1'b1;
            end
        end
    end

    // Write monitor: handshakes and stall stability, sampled mid-cycle.
    initial begin
        bit            prev_stall;
        logic [AB-1:0] held_addr;
        logic [CB-1:0] held_col;
        prev_stall = 0;
        held_addr  = '0;
        held_col   = '0;
        forever begin
            @(negedge clk);
            if (!reset_in) begin
                if (prev_stall) begin
                    check("hold_valid", 32'(pixel_valid_out), 32'd1);
                    check("hold_addr", 32'(pixel_addr_out), 32'(held_addr));
                    check("hold_color", 32'(pixel_color_out), 32'(held_col));
                end
                if (pixel_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (pixel_valid_out && !pixel_ready_in) stall_cycles++;
                if (pixel_valid_out && pixel_ready_in) begin
                    got_addr.push_back(32'(pixel_addr_out));
                    got_col.push_back(32'(pixel_color_out));
                    wr_total++;
                end
                prev_stall = pixel_valid_out && !pixel_ready_in;
                held_addr  = pixel_addr_out;
                held_col   = pixel_color_out;
            end else begin
                prev_stall = 0;
            end
        end
    end

    // Reference: pixel n of the stream lands at col n%w, row n/w.
    task automatic model(input int x, input int y, input int w, input int colours,
                         input int off, input int nbytes);
        int sbpp, cb, n, slot, field, c, r;
        exp_addr.delete();
        exp_col.delete();
        cum.delete();
        if (colours == 0 || colours > 16) sbpp = 8;
        else if (colours <= 2)            sbpp = 1;
        else if (colours <= 4)            sbpp = 2;
        else                              sbpp = 4;
        cb = (sbpp > CB) ? CB : sbpp;
        n = 0;
        for (int k = 0; k < nbytes; k++) begin
            for (int f = 0; f < 8 / sbpp; f++) begin
                slot  = (int'(data_q[k]) >> (8 - sbpp * (f + 1))) % (1 << sbpp);
                field = slot % (1 << cb);
                c = n % w;
                r = n / w;
                if (x + c < DW && y + r < DH) begin
                    exp_addr.push_back(32'((y + r) * DW + x + c));
                    exp_col.push_back(32'((off + field) % (1 << CB)));
                end
                n++;
            end
            cum.push_back(exp_addr.size());
        end
    endtask

    task automatic send_operand(input int idx, input logic [7:0] b);
        operand_in       = b;
        operand_count_in = 32'(idx);
        operand_valid_in = 1'b1;
        @(posedge clk); #1;
        last_t0 = cyc;
        @(posedge clk); #1;
        operand_valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic begin_cmd(input logic [7:0] op, input int x, input int y, input int w,
                             input int colours, input int off);
        logic [7:0] hdr[8];
        hdr[0] = 8'(x >> 8);
        hdr[1] = 8'(x);
        hdr[2] = 8'(y >> 8);
        hdr[3] = 8'(y);
        hdr[4] = 8'(w >> 8);
        hdr[5] = 8'(w);
        hdr[6] = 8'(colours);
        hdr[7] = 8'(off);
        got_addr.delete();
        got_col.delete();
        op_code_in       = op;
        op_code_valid_in = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_operand(i + 1, hdr[i]);
    endtask

    task automatic send_data(input int k);
        send_operand(9 + k, data_q[k]);
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (got_addr.size() < n && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic end_cmd();
        int t;
        t = 0;
        repeat (3) @(posedge clk);
        #1;
        op_code_valid_in = 1'b0;
        while (busy_out && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("busy_clear", 32'(busy_out), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check({tag, "_color"}, got_col[i], exp_col[i]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n0, x, y, w, colours, off, nb;
        int t2c[4];
        int t3c[4];
        int cpick[9];
        t2c   = '{15, 0, 1, 2};
        t3c   = '{1, 0, 1, 0};
        cpick = '{0, 1, 2, 3, 4, 5, 16, 17, 200};

        reset_in         = 1'b1;
        op_code_in       = 8'h00;
        op_code_valid_in = 1'b0;
        operand_in       = 8'h00;
        operand_valid_in = 1'b0;
        operand_count_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_in = 1'b0;

        // Reset state
        check("rst_valid", 32'(pixel_valid_out), 32'd0);
        check("rst_addr", 32'(pixel_addr_out), 32'd0);
        check("rst_color", 32'(pixel_color_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_overflow", 32'(overflow_out), 32'd0);
        check("rst_error", 32'(error_out), 32'd0);

        // Basic 4bpp draw, first-pixel latency
        data_q = '{8'h12, 8'h34};
        begin_cmd(8'h12, 50, 100, 20, 16, 0);
        first_valid_cyc = -1;
        send_data(0);
        t0 = last_t0;
        send_data(1);
        end_cmd();
        check("t1_latency", 32'(first_valid_cyc), 32'(t0 + 2));
        exp_addr.delete();
        exp_col.delete();
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(64050 + i));
            exp_col.push_back(32'(i + 1));
        end
        compare_writes("t1");

        // Palette offset wraps modulo 16
        begin_cmd(8'h12, 50, 100, 20, 16, 8'h0E);
        send_data(0);
        send_data(1);
        end_cmd();
        exp_addr.delete();
        exp_col.delete();
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(64050 + i));
            exp_col.push_back(32'(t2c[i]));
        end
        compare_writes("t2");

        // Right-edge clipping at 1bpp
        data_q = '{8'hA5};
        begin_cmd(8'h12, 636, 10, 8, 2, 0);
        send_data(0);
        end_cmd();
        exp_addr.delete();
        exp_col.delete();
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(10 * 640 + 636 + i));
            exp_col.push_back(32'(t3c[i]));
        end
        compare_writes("t3");

        // Other opcodes are ignored
        begin_cmd(8'h11, 0, 0, 4, 16, 0);
        send_data(0);
        check("badop_busy", 32'(busy_out), 32'd0);
        op_code_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("badop_writes", 32'(got_addr.size()), 32'd0);

        // Ready held low for 5 cycles mid-stream
        data_q = '{8'h96, 8'h3C};
        model(0, 0, 16, 2, 0, 2);
        stall_cycles = 0;
        begin_cmd(8'h12, 0, 0, 16, 2, 0);
        stall_at = wr_total + 3;
        send_data(0);
        send_data(1);
        end_cmd();
        check("t4_stall_cycles", 32'(stall_cycles), 32'd5);
        compare_writes("t4");

        // width==0 raises error and draws nothing
        data_q = '{8'hFF};
        begin_cmd(8'h12, 10, 10, 0, 16, 0);
        check("t5_error", 32'(error_out), 32'd1);
        send_data(0);
        end_cmd();
        check("t5_writes", 32'(got_addr.size()), 32'd0);
        check("t5_error_sticky", 32'(error_out), 32'd1);

        // Reset in the middle of a stream
        data_q = '{8'hFF, 8'hFF};
        begin_cmd(8'h12, 0, 0, 40, 2, 3);
        send_data(0);
        reset_in         = 1'b1;
        op_code_valid_in = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 32'(pixel_valid_out), 32'd0);
        check("midrst_addr", 32'(pixel_addr_out), 32'd0);
        check("midrst_color", 32'(pixel_color_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_error", 32'(error_out), 32'd0);
        reset_in = 1'b0;
        n0 = got_addr.size();
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_more", 32'(got_addr.size()), 32'(n0));

        // Overflow with ready held low, 1bpp, 3 bytes
        data_q = '{8'hC3, 8'h5A, 8'hFF};
        model(100, 50, 10, 2, 1, 2);
        ready_force_low = 1;
        begin_cmd(8'h12, 100, 50, 10, 2, 1);
        send_data(0);
        send_data(1);
        check("t6_no_overflow_yet", 32'(overflow_out), 32'd0);
        send_data(2);
        check("t6_overflow", 32'(overflow_out), 32'd1);
        ready_force_low = 0;
        wait_writes(16);
        end_cmd();
        compare_writes("t6");
        check("t6_overflow_sticky", 32'(overflow_out), 32'd1);

        reset_in = 1'b1;
        @(posedge clk); #1;
        reset_in = 1'b0;
        check("ovf_cleared", 32'(overflow_out), 32'd0);

        // Randomized commands with random backpressure
        ready_random = 1;
        for (int it = 0; it < 8; it++) begin
            x       = int'($urandom_range(0, 660));
            y       = int'($urandom_range(0, 402));
            w       = int'($urandom_range(1, 30));
            colours = cpick[$urandom_range(0, 8)];
            off     = int'($urandom_range(0, 255));
            nb      = int'($urandom_range(1, 5));
            data_q.delete();
            for (int k = 0; k < nb; k++) data_q.push_back(8'($urandom_range(0, 255)));
            model(x, y, w, colours, off, nb);
            begin_cmd(8'h12, x, y, w, colours, off);
            for (int k = 0; k < nb; k++) begin
                send_data(k);
                wait_writes(cum[k]);
            end
            end_cmd();
            compare_writes("rand");
        end
        ready_random = 0;
        check("rand_overflow", 32'(overflow_out), 32'd0);
        check("rand_error", 32'(error_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
